div_ctrl: RTL

//  Button-driven sequencer for the 8-to-16bit unsigned divider.
//  - Takes the debounced buttons and 8 slide switches.
//  - Loads the 16-bit dividend (high byte, then low byte) and the 8-bit divisor.
//  - Starts the divider, waits for completion, then drives the 16-bit display.
//  - Sits between the debounce stage and the divider datapath/display mux.

---
 rtl/div_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: button-driven sequencer for the 16-by-8 unsigned divider.
// Loads dividend high byte, dividend low byte, then divisor from the slide
// switches on rising edges of BTN[0]. It then starts the divider and waits
// for the result. The quotient or remainder is shown on the display.
// BTN[1] clears the sequence back to the high-byte step.
// Optional feature: define DIV_TIMEOUT_EN to abort S_WAIT after TIMEOUT cycles.
module div_ctrl #(
   parameter int unsigned TIMEOUT = 32
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [1:0]  BTN,
   input  logic [7:0]  SW,
   input  logic        DIV_DONE,
   input  logic [15:0] QUO,
   input  logic [7:0]  REM,
   output logic        DIV_START,
   output logic [15:0] DIVIDEND,
   output logic [7:0]  DIVISOR,
   output logic [15:0] DISP,
   output logic [2:0]  STATE,
   output logic        ERR
);

   typedef enum logic [2:0] {
      StHi    = 3'd0,
      StLo    = 3'd1,
      StDvs   = 3'd2,
      StStart = 3'd3,
      StWait  = 3'd4,
      StShow  = 3'd5,
      StErr   = 3'd6
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  btn_q;
   logic [1:0]  rise;
   logic [15:0] dividend_q, dividend_d;
   logic [7:0]  divisor_q, divisor_d;
   logic        err_q, err_d;
   logic        show_rem_q, show_rem_d;
   logic [15:0] quo_q, quo_d;
   logic [7:0]  rem_q, rem_d;
   logic        clear;

`ifdef DIV_TIMEOUT_EN
   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);
   logic [7:0] cnt_q, cnt_d;
`else
   // TIMEOUT has no effect without the wait timer.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   assign rise = BTN & ~btn_q;

   // State and datapath registers; reset samples BTN so a held button gives no edge.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q    <= StHi;
         btn_q      <= BTN;
         dividend_q <= 16'h0000;
         divisor_q  <= 8'h00;
         err_q      <= 1'b0;
         show_rem_q <= 1'b0;
         quo_q      <= 16'h0000;
         rem_q      <= 8'h00;
`ifdef DIV_TIMEOUT_EN
         cnt_q      <= 8'h00;
`endif
      end else begin
         state_q    <= state_d;
         btn_q      <= BTN;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         err_q      <= err_d;
         show_rem_q <= show_rem_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
`ifdef DIV_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   // Next-state and operand/result update logic; clear overrides the per-state action.
   always_comb begin
      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      err_d      = err_q;
      show_rem_d = show_rem_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      clear      = 1'b0;
`ifdef DIV_TIMEOUT_EN
      cnt_d      = cnt_q;
`endif

      case (state_q)
         StHi: begin
            clear = rise[1];
            if (rise[0]) begin
               dividend_d[15:8] = SW;
               state_d          = StLo;
            end
         end
         StLo: begin
            clear = rise[1];
            if (rise[0]) begin
               dividend_d[7:0] = SW;
               state_d         = StDvs;
            end
         end
         StDvs: begin
            clear = rise[1];
            if (rise[0]) begin
               divisor_d = SW;
               if (SW == 8'h00) begin
                  err_d   = 1'b1;
                  state_d = StErr;
               end else begin
                  state_d = StStart;
               end
            end
         end
         StStart: begin
            // The start pulse is already committed here, so buttons are not honoured.
            state_d = StWait;
`ifdef DIV_TIMEOUT_EN
            cnt_d   = 8'h00;
`endif
         end
         StWait: begin
            // Buttons are ignored; their edges are consumed by btn_q regardless.
            if (DIV_DONE) begin
               quo_d      = QUO;
               rem_d      = REM;
               show_rem_d = 1'b0;
               state_d    = StShow;
            end
`ifdef DIV_TIMEOUT_EN
            else if (cnt_q + 8'd1 == TimeoutCnt) begin
               err_d   = 1'b1;
               state_d = StErr;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         StShow: begin
            clear = rise[1];
            if (rise[0]) begin
               show_rem_d = ~show_rem_q;
            end
         end
         StErr: begin
            clear = rise[1];
         end
         default: begin
            clear = 1'b1;
         end
      endcase

      if (clear) begin
         state_d    = StHi;
         dividend_d = 16'h0000;
         divisor_d  = 8'h00;
         err_d      = 1'b0;
         show_rem_d = 1'b0;
         quo_d      = 16'h0000;
         rem_d      = 8'h00;
      end
   end

   // Output decode from registered state.
   always_comb begin
      DIV_START = (state_q == StStart);
      DIVIDEND  = dividend_q;
      DIVISOR   = divisor_q;
      STATE     = state_q;
      ERR       = err_q;
      case (state_q)
         StShow:  DISP = show_rem_q ? {8'h00, rem_q} : quo_q;
         StErr:   DISP = 16'hEEEE;
         default: DISP = dividend_q;
      endcase
   end

endmodule
